// File: rtl/xbar_pkg.sv
// Shared constants and state types for the AXI4-Lite single-master crossbar.
package xbar_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;

    localparam logic [31:0] DEF_MEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] DEF_MEM_MASK  = 32'hF800_0000;
    localparam logic [31:0] DEF_UART_BASE = 32'hA000_03F8;
    localparam logic [31:0] DEF_UART_MASK = 32'hFFFF_FFF8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_t;
    typedef enum logic [1:0] {W_COLLECT, W_FWD, W_RESP, W_ERR} wstate_t;

endpackage

// File: rtl/axi4lite_addr_decode.sv
// Combinational address map lookup: memory region, UART region, or unmapped.
module axi4lite_addr_decode
    import xbar_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(DEF_MEM_BASE),
    parameter logic [ADDR_WIDTH-1:0] MEM_MASK   = ADDR_WIDTH'(DEF_MEM_MASK),
    parameter logic [ADDR_WIDTH-1:0] UART_BASE  = ADDR_WIDTH'(DEF_UART_BASE),
    parameter logic [ADDR_WIDTH-1:0] UART_MASK  = ADDR_WIDTH'(DEF_UART_MASK)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_mem_o,
    output logic                  hit_uart_o,
    output logic                  miss_o
);

    assign hit_mem_o  = ((addr_i & MEM_MASK) == MEM_BASE);
    assign hit_uart_o = ((addr_i & UART_MASK) == UART_BASE);
    assign miss_o     = !(hit_mem_o || hit_uart_o);

endmodule

// File: rtl/axi4lite_xbar.sv
// Routes one master's AXI4-Lite reads/writes to memory (s0) or UART (s1); unmapped -> DECERR.
module axi4lite_xbar
    import xbar_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(DEF_MEM_BASE),
    parameter logic [ADDR_WIDTH-1:0] MEM_MASK   = ADDR_WIDTH'(DEF_MEM_MASK),
    parameter logic [ADDR_WIDTH-1:0] UART_BASE  = ADDR_WIDTH'(DEF_UART_BASE),
    parameter logic [ADDR_WIDTH-1:0] UART_MASK  = ADDR_WIDTH'(DEF_UART_MASK)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_arvalid_i,
    input  logic [ADDR_WIDTH-1:0]   m_araddr_i,
    output logic                    m_arready_o,
    output logic                    m_rvalid_o,
    output logic [1:0]              m_rresp_o,
    output logic [DATA_WIDTH-1:0]   m_rdata_o,
    input  logic                    m_rready_i,
    input  logic                    m_awvalid_i,
    input  logic [ADDR_WIDTH-1:0]   m_awaddr_i,
    output logic                    m_awready_o,
    input  logic                    m_wvalid_i,
    input  logic [DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m_wstrb_i,
    output logic                    m_wready_o,
    output logic                    m_bvalid_o,
    output logic [1:0]              m_bresp_o,
    input  logic                    m_bready_i,
    output logic                    s0_arvalid_o,
    output logic [ADDR_WIDTH-1:0]   s0_araddr_o,
    input  logic                    s0_arready_i,
    input  logic                    s0_rvalid_i,
    input  logic [1:0]              s0_rresp_i,
    input  logic [DATA_WIDTH-1:0]   s0_rdata_i,
    output logic                    s0_rready_o,
    output logic                    s0_awvalid_o,
    output logic [ADDR_WIDTH-1:0]   s0_awaddr_o,
    input  logic                    s0_awready_i,
    output logic                    s0_wvalid_o,
    output logic [DATA_WIDTH-1:0]   s0_wdata_o,
    output logic [DATA_WIDTH/8-1:0] s0_wstrb_o,
    input  logic                    s0_wready_i,
    input  logic                    s0_bvalid_i,
    input  logic [1:0]              s0_bresp_i,
    output logic                    s0_bready_o,
    output logic                    s1_arvalid_o,
    output logic [ADDR_WIDTH-1:0]   s1_araddr_o,
    input  logic                    s1_arready_i,
    input  logic                    s1_rvalid_i,
    input  logic [1:0]              s1_rresp_i,
    input  logic [DATA_WIDTH-1:0]   s1_rdata_i,
    output logic                    s1_rready_o,
    output logic                    s1_awvalid_o,
    output logic [ADDR_WIDTH-1:0]   s1_awaddr_o,
    input  logic                    s1_awready_i,
    output logic                    s1_wvalid_o,
    output logic [DATA_WIDTH-1:0]   s1_wdata_o,
    output logic [DATA_WIDTH/8-1:0] s1_wstrb_o,
    input  logic                    s1_wready_i,
    input  logic                    s1_bvalid_i,
    input  logic [1:0]              s1_bresp_i,
    output logic                    s1_bready_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // ---------------- read path ----------------
    rstate_t               rstate_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  rsel_q;
    logic                  r_hit_mem, r_hit_uart, r_miss;
    logic                  s_arready, s_rvalid;
    logic [1:0]            s_rresp;
    logic [DATA_WIDTH-1:0] s_rdata;

    axi4lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE), .MEM_MASK(MEM_MASK),
        .UART_BASE(UART_BASE), .UART_MASK(UART_MASK)
    ) u_rdec (
        .addr_i(m_araddr_i), .hit_mem_o(r_hit_mem), .hit_uart_o(r_hit_uart), .miss_o(r_miss)
    );

    assign s_arready = rsel_q ? s1_arready_i : s0_arready_i;
    assign s_rvalid  = rsel_q ? s1_rvalid_i  : s0_rvalid_i;
    assign s_rresp   = rsel_q ? s1_rresp_i   : s0_rresp_i;
    assign s_rdata   = rsel_q ? s1_rdata_i   : s0_rdata_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rstate_q <= R_IDLE;
            araddr_q <= '0;
            rsel_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: if (m_arvalid_i) begin
                    araddr_q <= m_araddr_i;
                    rsel_q   <= r_hit_uart && !r_hit_mem;
                    rstate_q <= r_miss ? R_ERR : R_ADDR;
                end
                R_ADDR:  if (s_arready) rstate_q <= R_DATA;
                R_DATA:  if (s_rvalid && m_rready_i) rstate_q <= R_IDLE;
                R_ERR:   if (m_rready_i) rstate_q <= R_IDLE;
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign m_arready_o  = (rstate_q == R_IDLE);
    assign s0_arvalid_o = (rstate_q == R_ADDR) && !rsel_q;
    assign s1_arvalid_o = (rstate_q == R_ADDR) && rsel_q;
    assign s0_araddr_o  = araddr_q;
    assign s1_araddr_o  = araddr_q;
    assign s0_rready_o  = (rstate_q == R_DATA) && !rsel_q && m_rready_i;
    assign s1_rready_o  = (rstate_q == R_DATA) && rsel_q && m_rready_i;

    // R channel: live pass-through from the selected slave, or the internal DECERR beat
    always_comb begin
        m_rvalid_o = 1'b0;
        m_rresp_o  = RESP_OKAY;
        m_rdata_o  = '0;
        case (rstate_q)
            R_DATA: begin
                m_rvalid_o = s_rvalid;
                m_rresp_o  = s_rresp;
                m_rdata_o  = s_rdata;
            end
            R_ERR: begin
                m_rvalid_o = 1'b1;
                m_rresp_o  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    // ---------------- write path ----------------
    wstate_t               wstate_q;
    logic                  aw_held_q, w_held_q, aw_pend_q, w_pend_q, wsel_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_take, w_take, aw_now, w_now, aw_left, w_left;
    logic [ADDR_WIDTH-1:0] waddr_now;
    logic                  w_hit_mem, w_hit_uart, w_miss;
    logic                  s_awready, s_wready, s_bvalid;
    logic [1:0]            s_bresp;

    assign m_awready_o = (wstate_q == W_COLLECT) && !aw_held_q;
    assign m_wready_o  = (wstate_q == W_COLLECT) && !w_held_q;
    assign aw_take     = m_awvalid_i && m_awready_o;
    assign w_take      = m_wvalid_i && m_wready_o;
    assign aw_now      = aw_held_q || aw_take;
    assign w_now       = w_held_q || w_take;
    // Decode the address that will be held after this edge so a same-cycle AW+W forwards next cycle
    assign waddr_now   = aw_held_q ? awaddr_q : m_awaddr_i;

    axi4lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE), .MEM_MASK(MEM_MASK),
        .UART_BASE(UART_BASE), .UART_MASK(UART_MASK)
    ) u_wdec (
        .addr_i(waddr_now), .hit_mem_o(w_hit_mem), .hit_uart_o(w_hit_uart), .miss_o(w_miss)
    );

    assign s_awready = wsel_q ? s1_awready_i : s0_awready_i;
    assign s_wready  = wsel_q ? s1_wready_i  : s0_wready_i;
    assign s_bvalid  = wsel_q ? s1_bvalid_i  : s0_bvalid_i;
    assign s_bresp   = wsel_q ? s1_bresp_i   : s0_bresp_i;
    assign aw_left   = aw_pend_q && !s_awready;
    assign w_left    = w_pend_q && !s_wready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate_q  <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            wsel_q    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (wstate_q)
                W_COLLECT: begin
                    if (aw_take) begin
                        awaddr_q  <= m_awaddr_i;
                        aw_held_q <= 1'b1;
                    end
                    if (w_take) begin
                        wdata_q  <= m_wdata_i;
                        wstrb_q  <= m_wstrb_i;
                        w_held_q <= 1'b1;
                    end
                    if (aw_now && w_now) begin
                        wsel_q    <= w_hit_uart && !w_hit_mem;
                        aw_pend_q <= !w_miss;
                        w_pend_q  <= !w_miss;
                        wstate_q  <= w_miss ? W_ERR : W_FWD;
                    end
                end
                W_FWD: begin
                    aw_pend_q <= aw_left;
                    w_pend_q  <= w_left;
                    if (!aw_left && !w_left) wstate_q <= W_RESP;
                end
                W_RESP: if (s_bvalid && m_bready_i) begin
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    wstate_q  <= W_COLLECT;
                end
                W_ERR: if (m_bready_i) begin
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    wstate_q  <= W_COLLECT;
                end
                default: wstate_q <= W_COLLECT;
            endcase
        end
    end

    assign s0_awvalid_o = (wstate_q == W_FWD) && aw_pend_q && !wsel_q;
    assign s1_awvalid_o = (wstate_q == W_FWD) && aw_pend_q && wsel_q;
    assign s0_wvalid_o  = (wstate_q == W_FWD) && w_pend_q && !wsel_q;
    assign s1_wvalid_o  = (wstate_q == W_FWD) && w_pend_q && wsel_q;
    assign s0_awaddr_o  = awaddr_q;
    assign s1_awaddr_o  = awaddr_q;
    assign s0_wdata_o   = wdata_q;
    assign s1_wdata_o   = wdata_q;
    assign s0_wstrb_o   = wstrb_q;
    assign s1_wstrb_o   = wstrb_q;
    assign s0_bready_o  = (wstate_q == W_RESP) && !wsel_q && m_bready_i;
    assign s1_bready_o  = (wstate_q == W_RESP) && wsel_q && m_bready_i;

    // B channel: live pass-through from the selected slave, or the internal DECERR beat
    always_comb begin
        m_bvalid_o = 1'b0;
        m_bresp_o  = RESP_OKAY;
        case (wstate_q)
            W_RESP: begin
                m_bvalid_o = s_bvalid;
                m_bresp_o  = s_bresp;
            end
            W_ERR: begin
                m_bvalid_o = 1'b1;
                m_bresp_o  = RESP_DECERR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_xbar.sv
// Scoreboard bench for axi4lite_xbar with simple memory/UART slave models.
module tb_axi4lite_xbar;
    import xbar_pkg::*;

    localparam int unsigned AW_W = 32;
    localparam int unsigned DW_W = 32;
    localparam int unsigned SW_W = 4;

    typedef struct packed { logic sel; logic [AW_W-1:0] addr; } ax_t;
    typedef struct packed { logic sel; logic [DW_W-1:0] data; logic [SW_W-1:0] strb; } wd_t;
    typedef struct packed { logic [1:0] resp; logic [DW_W-1:0] data; } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW_W-1:0] m_araddr;
    logic [1:0]      m_rresp, m_bresp;
    logic [DW_W-1:0] m_rdata, m_wdata;
    logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [AW_W-1:0] m_awaddr;
    logic [SW_W-1:0] m_wstrb;

    logic [1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [AW_W-1:0] s_araddr [2];
    logic [AW_W-1:0] s_awaddr [2];
    logic [DW_W-1:0] s_rdata  [2];
    logic [DW_W-1:0] s_wdata  [2];
    logic [SW_W-1:0] s_wstrb  [2];
    logic [1:0]      s_rresp  [2];
    logic [1:0]      s_bresp  [2];

    axi4lite_xbar dut (
        .clk(clk), .rst(rst),
        .m_arvalid_i(m_arvalid), .m_araddr_i(m_araddr), .m_arready_o(m_arready),
        .m_rvalid_o(m_rvalid), .m_rresp_o(m_rresp), .m_rdata_o(m_rdata), .m_rready_i(m_rready),
        .m_awvalid_i(m_awvalid), .m_awaddr_i(m_awaddr), .m_awready_o(m_awready),
        .m_wvalid_i(m_wvalid), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb), .m_wready_o(m_wready),
        .m_bvalid_o(m_bvalid), .m_bresp_o(m_bresp), .m_bready_i(m_bready),
        .s0_arvalid_o(s_arvalid[0]), .s0_araddr_o(s_araddr[0]), .s0_arready_i(s_arready[0]),
        .s0_rvalid_i(s_rvalid[0]), .s0_rresp_i(s_rresp[0]), .s0_rdata_i(s_rdata[0]), .s0_rready_o(s_rready[0]),
        .s0_awvalid_o(s_awvalid[0]), .s0_awaddr_o(s_awaddr[0]), .s0_awready_i(s_awready[0]),
        .s0_wvalid_o(s_wvalid[0]), .s0_wdata_o(s_wdata[0]), .s0_wstrb_o(s_wstrb[0]), .s0_wready_i(s_wready[0]),
        .s0_bvalid_i(s_bvalid[0]), .s0_bresp_i(s_bresp[0]), .s0_bready_o(s_bready[0]),
        .s1_arvalid_o(s_arvalid[1]), .s1_araddr_o(s_araddr[1]), .s1_arready_i(s_arready[1]),
        .s1_rvalid_i(s_rvalid[1]), .s1_rresp_i(s_rresp[1]), .s1_rdata_i(s_rdata[1]), .s1_rready_o(s_rready[1]),
        .s1_awvalid_o(s_awvalid[1]), .s1_awaddr_o(s_awaddr[1]), .s1_awready_i(s_awready[1]),
        .s1_wvalid_o(s_wvalid[1]), .s1_wdata_o(s_wdata[1]), .s1_wstrb_o(s_wstrb[1]), .s1_wready_i(s_wready[1]),
        .s1_bvalid_i(s_bvalid[1]), .s1_bresp_i(s_bresp[1]), .s1_bready_o(s_bready[1])
    );

    // slave model knobs and state
    int          ar_dly [2], r_dly [2], aw_dly [2], w_dly [2];
    int          ar_wait [2], r_wait [2], aw_wait [2], w_wait [2];
    bit          r_pend [2], aw_got [2], w_got [2];
    logic [31:0] rdata_val [2];
    logic [1:0]  rresp_val [2], bresp_val [2];
    logic [7:0]  uart_char;

    ax_t  ar_q[$];
    ax_t  aw_q[$];
    wd_t  w_q[$];
    rd_t  rd_q[$];
    logic [1:0] b_q[$];

    int errors = 0;
    int checks = 0;
    int r_done = 0;
    int b_done = 0;
    bit touched [2];

    // One clock: score handshakes pending at the edge, step the edge, update models.
    task automatic tick();
        bit mar, maw, mw, mr, mb, rst_pre;
        bit sar [2], sr [2], saw [2], sw [2], sb [2];
        ax_t ea; wd_t ew; rd_t er; logic [1:0] eb;
        #1;
        rst_pre = rst;
        mar = m_arvalid & m_arready;
        maw = m_awvalid & m_awready;
        mw  = m_wvalid & m_wready;
        mr  = m_rvalid & m_rready;
        mb  = m_bvalid & m_bready;
        for (int i = 0; i < 2; i++) begin
            sar[i] = s_arvalid[i] & s_arready[i];
            sr[i]  = s_rvalid[i] & s_rready[i];
            saw[i] = s_awvalid[i] & s_awready[i];
            sw[i]  = s_wvalid[i] & s_wready[i];
            sb[i]  = s_bvalid[i] & s_bready[i];
            if (s_arvalid[i] | s_awvalid[i] | s_wvalid[i] | s_rready[i] | s_bready[i]) touched[i] = 1'b1;
            if (sar[i]) begin
                checks++;
                if (ar_q.size() == 0) begin
                    errors++; $display("FAIL sb_ar: unexpected AR on s%0d addr=%h", i, s_araddr[i]);
                end else begin
                    ea = ar_q.pop_front();
                    if (i != int'(ea.sel) || s_araddr[i] !== ea.addr) begin
                        errors++; $display("FAIL sb_ar: got s%0d addr=%h, expected s%0d addr=%h", i, s_araddr[i], ea.sel, ea.addr);
                    end
                end
            end
            if (saw[i]) begin
                checks++;
                if (aw_q.size() == 0) begin
                    errors++; $display("FAIL sb_aw: unexpected AW on s%0d addr=%h", i, s_awaddr[i]);
                end else begin
                    ea = aw_q.pop_front();
                    if (i != int'(ea.sel) || s_awaddr[i] !== ea.addr) begin
                        errors++; $display("FAIL sb_aw: got s%0d addr=%h, expected s%0d addr=%h", i, s_awaddr[i], ea.sel, ea.addr);
                    end
                end
            end
            if (sw[i]) begin
                checks++;
                if (w_q.size() == 0) begin
                    errors++; $display("FAIL sb_w: unexpected W on s%0d data=%h", i, s_wdata[i]);
                end else begin
                    ew = w_q.pop_front();
                    if (i != int'(ew.sel) || s_wdata[i] !== ew.data || s_wstrb[i] !== ew.strb) begin
                        errors++; $display("FAIL sb_w: got s%0d data=%h strb=%b, expected s%0d data=%h strb=%b",
                                           i, s_wdata[i], s_wstrb[i], ew.sel, ew.data, ew.strb);
                    end
                end
            end
        end
        if (mr) begin
            checks++; r_done++;
            if (rd_q.size() == 0) begin
                errors++; $display("FAIL sb_r: unexpected R resp=%b data=%h", m_rresp, m_rdata);
            end else begin
                er = rd_q.pop_front();
                if (m_rresp !== er.resp || m_rdata !== er.data) begin
                    errors++; $display("FAIL sb_r: got resp=%b data=%h, expected resp=%b data=%h", m_rresp, m_rdata, er.resp, er.data);
                end
            end
        end
        if (mb) begin
            checks++; b_done++;
            if (b_q.size() == 0) begin
                errors++; $display("FAIL sb_b: unexpected B resp=%b", m_bresp);
            end else begin
                eb = b_q.pop_front();
                if (m_bresp !== eb) begin
                    errors++; $display("FAIL sb_b: got resp=%b, expected resp=%b", m_bresp, eb);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (mar) m_arvalid = 1'b0;
        if (maw) m_awvalid = 1'b0;
        if (mw)  m_wvalid  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!rst_pre) begin
                s_arready[i] = 1'b0; s_rvalid[i] = 1'b0; s_awready[i] = 1'b0;
                s_wready[i] = 1'b0; s_bvalid[i] = 1'b0;
                r_pend[i] = 1'b0; aw_got[i] = 1'b0; w_got[i] = 1'b0;
                ar_wait[i] = 0; aw_wait[i] = 0; w_wait[i] = 0;
            end else begin
                if (sar[i]) begin
                    s_arready[i] = 1'b0; ar_wait[i] = 0; r_pend[i] = 1'b1; r_wait[i] = r_dly[i];
                end else if (s_arvalid[i]) begin
                    if (ar_wait[i] >= ar_dly[i]) s_arready[i] = 1'b1; else ar_wait[i]++;
                end
                if (sr[i]) s_rvalid[i] = 1'b0;
                else if (r_pend[i]) begin
                    if (r_wait[i] == 0) begin
                        s_rvalid[i] = 1'b1; s_rdata[i] = rdata_val[i]; s_rresp[i] = rresp_val[i]; r_pend[i] = 1'b0;
                    end else r_wait[i]--;
                end
                if (saw[i]) begin
                    s_awready[i] = 1'b0; aw_wait[i] = 0; aw_got[i] = 1'b1;
                end else if (s_awvalid[i]) begin
                    if (aw_wait[i] >= aw_dly[i]) s_awready[i] = 1'b1; else aw_wait[i]++;
                end
                if (sw[i]) begin
                    s_wready[i] = 1'b0; w_wait[i] = 0; w_got[i] = 1'b1;
                    if (i == 1) uart_char = s_wdata[1][7:0];
                end else if (s_wvalid[i]) begin
                    if (w_wait[i] >= w_dly[i]) s_wready[i] = 1'b1; else w_wait[i]++;
                end
                if (sb[i]) s_bvalid[i] = 1'b0;
                else if (aw_got[i] && w_got[i]) begin
                    s_bvalid[i] = 1'b1; s_bresp[i] = bresp_val[i]; aw_got[i] = 1'b0; w_got[i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic wait_done(input int rt, input int bt, input int limit, input string name);
        int n = 0;
        while ((r_done < rt || b_done < bt) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (r_done < rt || b_done < bt) begin
            errors++;
            $display("FAIL %s: timeout with r_done=%0d b_done=%0d, required r=%0d b=%0d", name, r_done, b_done, rt, bt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({m_arready, m_awready, m_wready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b, expected 111", {m_arready, m_awready, m_wready});
        end
        checks++;
        if ({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid} !== 8'h00) begin
            errors++; $display("FAIL reset_valid: got %b, expected 00000000", {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mem_read();
        int r0 = r_done;
        rdata_val[0] = 32'hDEAD_BEEF; r_dly[0] = 2;
        ar_q.push_back('{sel: 1'b0, addr: 32'h8000_0010});
        rd_q.push_back('{resp: RESP_OKAY, data: 32'hDEAD_BEEF});
        touched[1] = 1'b0;
        m_araddr = 32'h8000_0010; m_arvalid = 1'b1;
        tick();
        checks++;
        if ({s_arvalid[0], s_arvalid[1], s_araddr[0]} !== {2'b10, 32'h8000_0010}) begin
            errors++; $display("FAIL rd_ar_latency: got arvalid=%b addr=%h, expected 10 addr=80000010", {s_arvalid[0], s_arvalid[1]}, s_araddr[0]);
        end
        wait_done(r0 + 1, 0, 30, "rd_mem_done");
        checks++;
        if (touched[1] !== 1'b0) begin
            errors++; $display("FAIL rd_s1_idle: s1 touched=%b, expected 0", touched[1]);
        end
        r_dly[0] = 0;
    endtask

    task automatic test_uart_write();
        int b0 = b_done;
        uart_char = 8'h00;
        aw_q.push_back('{sel: 1'b1, addr: 32'hA000_03F8});
        w_q.push_back('{sel: 1'b1, data: 32'h0000_0041, strb: 4'b0001});
        b_q.push_back(RESP_OKAY);
        m_awaddr = 32'hA000_03F8; m_wdata = 32'h41; m_wstrb = 4'b0001;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        tick();
        checks++;
        if ({s_awvalid[1], s_wvalid[1], s_awvalid[0], s_wvalid[0]} !== 4'b1100) begin
            errors++; $display("FAIL wr_latency: got %b, expected 1100", {s_awvalid[1], s_wvalid[1], s_awvalid[0], s_wvalid[0]});
        end
        wait_done(0, b0 + 1, 30, "wr_uart_done");
        checks++;
        if (uart_char !== 8'h41) begin
            errors++; $display("FAIL wr_uart_char: got %h, expected 41", uart_char);
        end
    endtask

    task automatic test_w_before_aw();
        int b0 = b_done;
        aw_q.push_back('{sel: 1'b1, addr: 32'hA000_03F9});
        w_q.push_back('{sel: 1'b1, data: 32'h0000_0042, strb: 4'b0001});
        b_q.push_back(RESP_OKAY);
        m_wdata = 32'h42; m_wstrb = 4'b0001; m_wvalid = 1'b1;
        tick();
        checks++;
        if ({m_wready, m_awready} !== 2'b01) begin
            errors++; $display("FAIL wfirst_ready: got wready/awready=%b, expected 01", {m_wready, m_awready});
        end
        tick(); tick();
        checks++;
        if ({s_wvalid, s_awvalid} !== 4'b0000) begin
            errors++; $display("FAIL wfirst_hold: got wvalid/awvalid=%b, expected 0000", {s_wvalid, s_awvalid});
        end
        m_awaddr = 32'hA000_03F9; m_awvalid = 1'b1;
        tick();
        checks++;
        if ({s_awvalid[1], s_wvalid[1]} !== 2'b11) begin
            errors++; $display("FAIL wfirst_fwd: got %b, expected 11", {s_awvalid[1], s_wvalid[1]});
        end
        wait_done(0, b0 + 1, 30, "wfirst_done");
        repeat (5) tick();
        checks++;
        if (b_done !== b0 + 1) begin
            errors++; $display("FAIL wfirst_one_b: got %0d B, expected 1", b_done - b0);
        end
    endtask

    task automatic test_decerr();
        int r0 = r_done;
        int b0 = b_done;
        touched[0] = 1'b0; touched[1] = 1'b0;
        rd_q.push_back('{resp: RESP_DECERR, data: 32'h0});
        m_rready = 1'b0;
        m_araddr = 32'h1000_0000; m_arvalid = 1'b1;
        tick();
        checks++;
        if ({m_rvalid, m_rresp, m_rdata} !== {1'b1, 2'b11, 32'h0}) begin
            errors++; $display("FAIL decerr_r: got valid=%b resp=%b data=%h, expected 1 11 00000000", m_rvalid, m_rresp, m_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({m_rvalid, m_rresp, m_rdata, m_arready} !== {1'b1, 2'b11, 32'h0, 1'b0}) begin
                errors++; $display("FAIL decerr_hold%0d: got valid=%b resp=%b data=%h arready=%b, expected 1 11 0 0",
                                   k, m_rvalid, m_rresp, m_rdata, m_arready);
            end
        end
        m_rready = 1'b1;
        wait_done(r0 + 1, 0, 10, "decerr_r_done");
        b_q.push_back(RESP_DECERR);
        m_awaddr = 32'h2000_0000; m_wdata = 32'hCAFE; m_wstrb = 4'hF;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        wait_done(0, b0 + 1, 10, "decerr_b_done");
        checks++;
        if ({touched[0], touched[1]} !== 2'b00) begin
            errors++; $display("FAIL decerr_slaves_idle: got touched=%b, expected 00", {touched[0], touched[1]});
        end
    endtask

    task automatic test_concurrent();
        for (int it = 0; it < 4; it++) begin
            int r0 = r_done;
            int b0 = b_done;
            logic [1:0] br;
            ar_dly[0] = int'($urandom_range(0, 7));
            r_dly[0]  = int'($urandom_range(0, 7));
            aw_dly[1] = int'($urandom_range(0, 3));
            w_dly[1]  = int'($urandom_range(0, 3));
            rdata_val[0] = $urandom;
            br = (it % 2 == 1) ? 2'b10 : RESP_OKAY;
            bresp_val[1] = br;
            ar_q.push_back('{sel: 1'b0, addr: 32'h8000_0100 + 32'(it * 4)});
            rd_q.push_back('{resp: RESP_OKAY, data: rdata_val[0]});
            aw_q.push_back('{sel: 1'b1, addr: 32'hA000_03FC});
            w_q.push_back('{sel: 1'b1, data: 32'h30 + 32'(it), strb: 4'b0001});
            b_q.push_back(br);
            m_araddr = 32'h8000_0100 + 32'(it * 4); m_arvalid = 1'b1;
            m_awaddr = 32'hA000_03FC; m_wdata = 32'h30 + 32'(it); m_wstrb = 4'b0001;
            m_awvalid = 1'b1; m_wvalid = 1'b1;
            wait_done(r0 + 1, b0 + 1, 100, "concurrent_done");
        end
        ar_dly[0] = 0; r_dly[0] = 0; aw_dly[1] = 0; w_dly[1] = 0; bresp_val[1] = RESP_OKAY;
    endtask

    task automatic test_reset_mid();
        int r0;
        ar_dly[0] = 20; aw_dly[0] = 20; w_dly[0] = 20;
        m_araddr = 32'h8000_0020; m_arvalid = 1'b1;
        m_awaddr = 32'h8000_0040; m_wdata = 32'h1111; m_wstrb = 4'hF;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        tick(); tick();
        checks++;
        if ({s_arvalid[0], s_awvalid[0], s_wvalid[0]} !== 3'b111) begin
            errors++; $display("FAIL rstmid_pre: got %b, expected 111", {s_arvalid[0], s_awvalid[0], s_wvalid[0]});
        end
        ar_dly[0] = 0; aw_dly[0] = 0; w_dly[0] = 0;
        rst = 1'b0;
        tick();
        checks++;
        if ({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid, m_arready, m_awready, m_wready} !== 11'b000_0000_0111) begin
            errors++; $display("FAIL rstmid_out: got %b, expected 00000000111",
                               {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid, m_arready, m_awready, m_wready});
        end
        rst = 1'b1;
        tick();
        r0 = r_done;
        rdata_val[0] = 32'h1234_5678;
        ar_q.push_back('{sel: 1'b0, addr: 32'h8000_0000});
        rd_q.push_back('{resp: RESP_OKAY, data: 32'h1234_5678});
        m_araddr = 32'h8000_0000; m_arvalid = 1'b1;
        wait_done(r0 + 1, 0, 30, "rstmid_read_done");
    endtask

    task automatic test_drain();
        int left;
        repeat (3) tick();
        left = ar_q.size() + aw_q.size() + w_q.size() + rd_q.size() + b_q.size();
        checks++;
        if (left != 0) begin
            errors++; $display("FAIL drain: %0d expected transactions never seen, expected 0", left);
        end
    endtask

    initial begin
        m_arvalid = 1'b0; m_araddr = '0; m_rready = 1'b1;
        m_awvalid = 1'b0; m_awaddr = '0; m_wvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_bready = 1'b1;
        s_arready = '0; s_rvalid = '0; s_awready = '0; s_wready = '0; s_bvalid = '0;
        uart_char = 8'h00;
        for (int i = 0; i < 2; i++) begin
            s_rdata[i] = '0; s_rresp[i] = RESP_OKAY; s_bresp[i] = RESP_OKAY;
            ar_dly[i] = 0; r_dly[i] = 0; aw_dly[i] = 0; w_dly[i] = 0;
            ar_wait[i] = 0; r_wait[i] = 0; aw_wait[i] = 0; w_wait[i] = 0;
            r_pend[i] = 1'b0; aw_got[i] = 1'b0; w_got[i] = 1'b0;
            rdata_val[i] = '0; rresp_val[i] = RESP_OKAY; bresp_val[i] = RESP_OKAY;
            touched[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_mem_read();
        test_uart_write();
        test_w_before_aw();
        test_decerr();
        test_concurrent();
        test_reset_mid();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
